// File: rtl/pe_pkg.sv
// Shared widths, FSM state type and filter packing for the PE row sequencer.
package pe_pkg;

  localparam int unsigned IFMAP_W = 8;
  localparam int unsigned WGT_W   = 4;
  localparam int unsigned TAPS    = 3;
  localparam int unsigned PSUM_W  = 14;
  localparam int unsigned FILT_W  = TAPS * WGT_W;

  typedef enum logic [2:0] {
    StIdle,
    StWload,
    StStream,
    StDrain,
    StDone
  } state_e;

  // Tap 0 lands in the LSBs, tap TAPS-1 in the MSBs.
  function automatic logic [FILT_W-1:0] pack_filter(input logic [TAPS-1:0][WGT_W-1:0] taps);
    logic [FILT_W-1:0] f;
    f = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      f[i*WGT_W +: WGT_W] = taps[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/pe_row_buf.sv
// Row sample register file: one synchronous write port, one combinational read port.
module pe_row_buf
  import pe_pkg::*;
#(
  parameter int unsigned ROW_LEN = 16,
  parameter int unsigned AW      = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [IFMAP_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [IFMAP_W-1:0] rdata
);

  logic [IFMAP_W-1:0] mem [ROW_LEN];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_row_sequencer.sv
// Initiator-side driver for a 3-tap PE: buffers a row, streams it in, captures
// one partial sum per valid convolution window.
module pe_row_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned ROW_LEN = 16,
  parameter int unsigned PE_LAT  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ld_valid,
  input  logic [IFMAP_W-1:0]               ld_data,
  output logic                             ld_ready,
  input  logic                             start,
  input  logic [$clog2(ROW_LEN+1)-1:0]     row_len,
  input  logic [TAPS*WGT_W-1:0]            wgt_in,
  input  logic [PSUM_W-1:0]                bias_in,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             pe_en,
  output logic [TAPS*WGT_W-1:0]            pe_filtr,
  output logic [IFMAP_W-1:0]               pe_ifmap,
  output logic [PSUM_W-1:0]                pe_psum,
  input  logic [PSUM_W-1:0]                pe_psum_ret,
  output logic                             res_valid,
  output logic [PSUM_W-1:0]                res_data
);

  localparam int unsigned LW = $clog2(ROW_LEN + 1);
  localparam int unsigned AW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  state_e            state_q;
  logic [LW-1:0]     wr_ptr_q;
  logic [LW-1:0]     row_len_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [DW-1:0]     drain_q;
  logic [PE_LAT-1:0] vpipe_q;

  logic               start_ok;
  logic               buf_we;
  logic               issue;
  logic               last_k;
  logic [AW-1:0]      rd_addr;
  logic [IFMAP_W-1:0] rd_data;

  assign start_ok = (state_q == StIdle) && start && (row_len >= LW'(TAPS)) &&
                    (row_len <= wr_ptr_q);
  // A load coinciding with an accepted start is not written.
  assign buf_we   = (state_q == StIdle) && ld_valid && ld_ready && !start_ok;
  // rd_ptr_q is the sample currently on pe_ifmap, so look one ahead.
  assign rd_addr  = (state_q == StStream) ? rd_ptr_q + AW'(1) : '0;
  assign issue    = (state_q == StStream) && (LW'(rd_ptr_q) >= LW'(TAPS - 1));
  assign last_k   = (LW'(rd_ptr_q) + LW'(1)) == row_len_q;

  pe_row_buf #(
    .ROW_LEN (ROW_LEN),
    .AW      (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      row_len_q <= '0;
      rd_ptr_q  <= '0;
      drain_q   <= '0;
      vpipe_q   <= '0;
      ld_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pe_en     <= 1'b0;
      pe_filtr  <= '0;
      pe_ifmap  <= '0;
      pe_psum   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      err       <= 1'b0;
      done      <= 1'b0;
      vpipe_q   <= PE_LAT'({vpipe_q, issue});
      res_valid <= vpipe_q[PE_LAT-1];
      res_data  <= vpipe_q[PE_LAT-1] ? pe_psum_ret : '0;

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q   <= StWload;
            row_len_q <= row_len;
            pe_filtr  <= pack_filter(wgt_in);
            pe_psum   <= bias_in;
            pe_en     <= 1'b1;
            busy      <= 1'b1;
            ld_ready  <= 1'b0;
          end else begin
            err <= start;
            if (buf_we) begin
              wr_ptr_q <= wr_ptr_q + LW'(1);
              ld_ready <= (wr_ptr_q + LW'(1)) < LW'(ROW_LEN);
            end else begin
              ld_ready <= wr_ptr_q < LW'(ROW_LEN);
            end
          end
        end
        StWload: begin
          state_q  <= StStream;
          rd_ptr_q <= '0;
          pe_ifmap <= rd_data;
        end
        StStream: begin
          if (last_k) begin
            state_q  <= StDrain;
            drain_q  <= '0;
            pe_ifmap <= '0;
          end else begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            pe_ifmap <= rd_data;
          end
        end
        StDrain: begin
          if (drain_q == DW'(PE_LAT - 1)) begin
            state_q <= StDone;
            busy    <= 1'b0;
            pe_en   <= 1'b0;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        StDone: begin
          state_q  <= StIdle;
          wr_ptr_q <= '0;
          done     <= 1'b1;
          ld_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Randomized self-checking bench for pe_row_sequencer with a PE stub and a
// cycle-indexed behavioural model of the row transaction.
module tb_pe_row_sequencer;
  import pe_pkg::*;

  localparam int RL = 16;
  localparam int PL = 1;
  localparam int NT = int'(TAPS);
  localparam int LW = $clog2(RL + 1);
  localparam int PMASK = (1 << PSUM_W) - 1;

  logic                 clk, rst_n;
  logic                 ld_valid, ld_ready, start, busy, done, err, pe_en, res_valid;
  logic [IFMAP_W-1:0]   ld_data, pe_ifmap;
  logic [LW-1:0]        row_len;
  logic [FILT_W-1:0]    wgt_in, pe_filtr;
  logic [PSUM_W-1:0]    bias_in, pe_psum, pe_psum_ret, res_data;

  pe_row_sequencer #(
    .ROW_LEN (RL),
    .PE_LAT  (PL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .start       (start),
    .row_len     (row_len),
    .wgt_in      (wgt_in),
    .bias_in     (bias_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pe_en       (pe_en),
    .pe_filtr    (pe_filtr),
    .pe_ifmap    (pe_ifmap),
    .pe_psum     (pe_psum),
    .pe_psum_ret (pe_psum_ret),
    .res_valid   (res_valid),
    .res_data    (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE stub: either a plain one-cycle delay of pe_ifmap or a real 3-tap MAC.
  bit                 stub_conv;
  logic [IFMAP_W-1:0] stub_s1, stub_s2;
  int                 stub_sum;
  assign stub_sum = int'(pe_psum) + int'(pe_filtr[3:0]) * int'(stub_s2) +
                    int'(pe_filtr[7:4]) * int'(stub_s1) + int'(pe_filtr[11:8]) * int'(pe_ifmap);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_s1     <= '0;
      stub_s2     <= '0;
      pe_psum_ret <= '0;
    end else if (pe_en) begin
      stub_s1     <= pe_ifmap;
      stub_s2     <= stub_s1;
      pe_psum_ret <= stub_conv ? PSUM_W'(stub_sum) : PSUM_W'(pe_ifmap);
    end
  end

  int total, bad;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model state
  int m_buf [RL];
  int m_wr;
  int m_row [RL];
  int m_len, m_bias;
  int m_filt;
  int exp_res [RL];
  int res_log [RL];
  int res_n;
  bit mdl_active;
  int mdl_cyc;
  int cc, lo, hi;

  // Cycle c=0 is the first cycle after the accepted start edge.
  always @(negedge clk) begin
    if (mdl_active) begin
      cc = mdl_cyc;
      lo = NT + 1 + PL;
      hi = m_len + 1 + PL;
      chk("busy", int'(busy), int'(cc <= m_len + PL));
      chk("pe_en", int'(pe_en), int'(cc <= m_len + PL));
      chk("pe_ifmap", int'(pe_ifmap), (cc >= 1 && cc <= m_len) ? m_row[cc-1] : 0);
      chk("pe_filtr", int'(pe_filtr), m_filt);
      chk("pe_psum", int'(pe_psum), m_bias);
      chk("ld_ready", int'(ld_ready), int'(cc >= m_len + PL + 2));
      chk("done", int'(done), int'(cc == m_len + PL + 2));
      chk("err", int'(err), 0);
      chk("res_valid", int'(res_valid), int'(cc >= lo && cc <= hi));
      if (res_valid && res_n < RL) begin
        res_log[res_n] = int'(res_data);
        res_n++;
      end
      if (cc >= lo && cc <= hi) chk("res_data", int'(res_data), exp_res[cc-lo]);
      mdl_cyc++;
      if (mdl_cyc > m_len + PL + 3) mdl_active = 1'b0;
    end
  end

  task automatic load_sample(input int v);
    @(posedge clk);
    #1;
    ld_valid = 1'b1;
    ld_data  = IFMAP_W'(v);
    chk("ld_ready_load", int'(ld_ready), int'(m_wr < RL));
    if (m_wr < RL) begin
      m_buf[m_wr] = v;
      m_wr++;
    end
  endtask

  task automatic load_end();
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic start_row(input int len, input int wgt, input int bias, input bit conv);
    bit ok;
    int s;
    ok = (len >= NT) && (len <= m_wr);
    stub_conv = conv;
    @(posedge clk);
    #1;
    start   = 1'b1;
    row_len = LW'(len);
    wgt_in  = FILT_W'(wgt);
    bias_in = PSUM_W'(bias);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ok) begin
      m_len  = len;
      m_bias = bias;
      m_filt = wgt;
      for (int i = 0; i < len; i++) m_row[i] = m_buf[i];
      for (int j = 0; j <= len - NT; j++) begin
        if (conv) begin
          s = bias;
          for (int t = 0; t < NT; t++) s += ((wgt >> (4 * t)) & 15) * m_row[j+t];
          exp_res[j] = s & PMASK;
        end else begin
          exp_res[j] = m_row[j+NT-1];
        end
      end
      m_wr       = 0;
      res_n      = 0;
      mdl_cyc    = 0;
      mdl_active = 1'b1;
    end else begin
      chk("err_pulse", int'(err), 1);
      chk("busy_on_err", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("err_one_cycle", int'(err), 0);
    end
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (mdl_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("run_timeout", int'(mdl_active), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ld_ready"}, int'(ld_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_pe_en"}, int'(pe_en), 0);
    chk({tag, "_pe_filtr"}, int'(pe_filtr), 0);
    chk({tag, "_pe_ifmap"}, int'(pe_ifmap), 0);
    chk({tag, "_pe_psum"}, int'(pe_psum), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_data"}, int'(res_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, cnt;
    bit saw_done;
    total = 0; bad = 0; m_wr = 0; res_n = 0; mdl_active = 1'b0; mdl_cyc = 0;
    stub_conv = 1'b0;
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
    row_len = '0; wgt_in = '0; bias_in = '0;
    #12;
    check_zero("reset");
    #11 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed row with a delay-line PE
    load_sample(2); load_sample(4); load_sample(1); load_sample(0); load_end();
    start_row(4, 'h431, 1, 1'b0);
    wait_run();
    chk("t1_count", res_n, 2);
    chk("t1_res0", res_log[0], 1);
    chk("t1_res1", res_log[1], 0);
    chk("t1_filtr_hold", int'(pe_filtr), 'h431);

    // Real 3-tap MAC: weights 4,3,1 on row 1..8 with bias 1
    for (int i = 1; i <= 8; i++) load_sample(i);
    load_end();
    start_row(8, 'h134, 1, 1'b1);
    wait_run();
    chk("t2_count", res_n, 6);
    chk("t2_res0", res_log[0], 14);
    chk("t2_res5", res_log[5], 54);

    // Rejected starts
    load_sample(7); load_sample(9); load_end();
    start_row(2, 'h111, 0, 1'b1);
    load_sample(5); load_sample(3); load_end();
    start_row(5, 'h111, 0, 1'b1);
    start_row(4, 'h213, 5, 1'b1);
    wait_run();
    chk("t3_count", res_n, 2);

    // Overfill: 17th sample dropped, full-length row
    for (int i = 0; i < 17; i++) load_sample(int'($urandom_range(0, 255)));
    load_end();
    chk("t4_ready_full", int'(ld_ready), 0);
    start_row(16, int'($urandom_range(0, 4095)), int'($urandom_range(0, PMASK)), 1'b1);
    wait_run();
    chk("t4_count", res_n, 14);

    // Reset mid-stream aborts without done
    for (int i = 0; i < 10; i++) load_sample(int'($urandom_range(0, 255)));
    load_end();
    start_row(10, 'h5a7, 3, 1'b1);
    n = 0;
    while (mdl_cyc < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_stream", int'(mdl_cyc >= 5), 1);
    @(posedge clk);
    #2;
    mdl_active = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    m_wr = 0;
    #10 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t5_no_done", int'(saw_done), 0);
    for (int i = 0; i < 5; i++) load_sample(int'($urandom_range(0, 255)));
    load_end();
    start_row(5, 'h321, 7, 1'b1);
    wait_run();
    chk("t5_count", res_n, 3);

    // Start pulsed mid-stream is ignored
    for (int i = 0; i < 6; i++) load_sample(int'($urandom_range(0, 255)));
    load_end();
    start_row(6, 'hfff, 100, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    row_len = LW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_run();
    chk("t6_count", res_n, 4);

    // Randomized rows
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(NT, RL));
      cnt = len + int'($urandom_range(0, 2));
      if (cnt > RL) cnt = RL;
      for (int i = 0; i < cnt; i++) load_sample(int'($urandom_range(0, 255)));
      load_end();
      start_row(len, int'($urandom_range(0, 4095)), int'($urandom_range(0, PMASK)),
                1'b1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_run();
      chk("rand_count", res_n, len - NT + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_row_sequencer.md
Name: pe_row_sequencer

Overview:
- Initiator-side driver for one 3-tap PE.
- Buffers one ifmap row, presents the packed filter weights, and shifts the row into the PE one sample per cycle. It also drives the bias partial sum.
- Captures the PE's returned partial sums at the correct latency, discarding warm-up outputs, and emits one result per valid convolution window.
- Sits between the row-load interface and the PE.

Parameters:
IFMAP_W, 8, ifmap sample width
WGT_W, 4, single weight width
TAPS, 3, filter taps; packed filter width = TAPS*WGT_W
PSUM_W, 14, partial-sum width
ROW_LEN, 16, max samples per row (buffer depth)
PE_LAT, 1, cycles from a sample on pe_ifmap to its window's sum on pe_psum_ret

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  row sample write strobe
ld_data  in  IFMAP_W  row sample
ld_ready  out  1  buffer accepts a sample
start  in  1  begin convolution of the buffered row
row_len  in  clog2(ROW_LEN+1)  samples to process
wgt_in  in  TAPS*WGT_W  packed weights, latched on start
bias_in  in  PSUM_W  bias driven on pe_psum, latched on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of row
err  out  1  one-cycle pulse on rejected start
pe_en  out  1  PE enable
pe_filtr  out  TAPS*WGT_W  weights to PE
pe_ifmap  out  IFMAP_W  sample shifted into PE
pe_psum  out  PSUM_W  bias partial sum to PE
pe_psum_ret  in  PSUM_W  PE partial-sum output
res_valid  out  1  result strobe (no backpressure)
res_data  out  PSUM_W  captured partial sum

Behaviour:
- Reset: all outputs are 0, state is IDLE, wr_ptr, rd_ptr and the valid pipe are 0, and the buffer contents are don't-care. Reset asserted mid-row aborts immediately; no done is issued.
- FSM: IDLE -> WLOAD -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - ld_ready = (wr_ptr < ROW_LEN).
  - When ld_valid && ld_ready, write buf[wr_ptr] and increment wr_ptr.
  - When ld_valid and the buffer is full, the sample is dropped silently.
- start in IDLE is accepted only if TAPS <= row_len <= wr_ptr.
  - If not, pulse err the next cycle and stay in IDLE.
  - A load on the same cycle as an accepted start is not written.
- start outside IDLE is ignored, with no err.
- WLOAD (1 cycle):
  - Latch wgt_in into pe_filtr and bias_in into pe_psum.
  - pe_en=1, busy=1, ld_ready=0, pe_ifmap=0.
- STREAM:
  - Cycle k (k = 0..row_len-1) drives pe_ifmap = buf[k], with pe_en=1.
  - The issue-valid bit (k >= TAPS-1) enters a PE_LAT-deep shift pipe.
  - Go to DRAIN after k = row_len-1.
- DRAIN:
  - pe_ifmap=0 and pe_en=1 for PE_LAT cycles, so the last window emerges.
- Capture: when the pipe output is 1, res_valid=1 and res_data = pe_psum_ret sampled that cycle.
  - Exactly row_len-TAPS+1 results per row, contiguous, in window order.
  - res_valid/res_data are registered from the pipe output and pe_psum_ret.
- DONE (1 cycle):
  - done=1 and busy=0.
  - wr_ptr cleared; the next row must be reloaded.
  - pe_en=0 and pe_filtr holds.
  - Return to IDLE.
- pe_filtr packing: tap0 occupies the LSBs, tap TAPS-1 the MSBs.
- No arithmetic is done in this block; widths pass through unchanged.

Decomposition:
- Shared package pe_pkg: IFMAP_W, WGT_W, TAPS, PSUM_W, the state enum (IDLE, WLOAD, STREAM, DRAIN, DONE), and the pe_filtr packing helper function.
- One natural sub-module: pe_row_buf, a ROW_LEN x IFMAP_W register file with one write port and one read port (synchronous write, combinational read).
- The FSM, counters and valid pipe stay in the top.

Test Plan:
- Load 2,4,1,0; start row_len=4, wgt_in=12'h431, bias_in=1, PE_LAT=1. The stub sets pe_psum_ret = delayed pe_ifmap.
  - Required: pe_filtr=12'h431 from WLOAD onward, and pe_ifmap sequence 2,4,1,0.
  - Exactly 2 results, with res_data = 1 then 0, captured at k=2 and k=3 plus 1 cycle.
  - done pulses 1 cycle after the last result.
- Behavioural 3-tap PE model: weights 4,3,1; row 1..8; bias 1.
  - Required: 6 results matching the model, contiguous res_valid, no result during warm-up.
- Load 2 samples, start row_len=2 -> err pulse, busy stays 0. start with row_len=5 > wr_ptr=4 -> err pulse.
- Write 17 samples with ROW_LEN=16 -> ld_ready drops after the 16th; sample 17 is not stored. A full-length row yields 14 results.
- Assert rst_n low mid-STREAM -> all outputs 0 asynchronously, no done. A reload plus start then runs cleanly.
- start pulsed during STREAM -> ignored: result count and timing are unchanged, with no err.
